sha256_msg_schedule: RTL and testbench

- Downstream neighbour of the SHA-256 preprocessor; sits between it and the compression rounds.
- Accepts one padded 512-bit block through a valid/ready handshake.
- Emits the 64 message-schedule words W0..W63, one per handshake, with index and last flags, to the compression core.
- Uses a 16-word sliding window, so no 64-word storage is needed.

---
 rtl/sha256_msg_schedule.sv | 111 +++++++++++
 tb/tb_sha256_msg_schedule.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - SHA-256 message schedule (16-word sliding window); optional SHA256_SCHED_B2B_EN
module sha256_msg_schedule #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              blk_valid,
    output logic              blk_ready,
    input  logic [511:0]      blk_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_data,
    output logic [5:0]        w_idx,
    output logic              w_last,
    output logic              busy
);

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WORD_W-1:0] win [16];
    logic [WORD_W-1:0] w_new;
    logic              blk_fire;
    logic              w_fire;
    logic              at_last;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    assign w_valid  = (state == RUN);
    assign busy     = (state == RUN);
    assign w_data   = win[0];
    assign at_last  = (w_idx == LAST_IDX);
    assign w_last   = w_valid && at_last;
    assign blk_fire = blk_valid && blk_ready;
    assign w_fire   = w_valid && w_ready;

    // Next schedule word; still computed past t=48 even though never emitted.
    assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and block-accept ready; ready is held low during reset.
    always_comb begin
        state_nxt = state;
        blk_ready = 1'b0;
        case (state)
            IDLE: begin
                blk_ready = !rst;
                if (blk_fire) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
`ifdef SHA256_SCHED_B2B_EN
                blk_ready = !rst && at_last && w_ready;
`else
                blk_ready = 1'b0;
`endif
                if (w_fire && at_last) begin
                    state_nxt = blk_fire ? RUN : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Window load on block accept, shift and extend on each word handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
            w_idx <= '0;
        end else if (blk_fire) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= blk_data[511 - 32*i -: 32];
            end
            w_idx <= '0;
        end else if (w_fire) begin
            for (int i = 0; i < 15; i++) begin
                win[i] <= win[i+1];
            end
            win[15] <= w_new;
            w_idx   <= at_last ? 6'd0 : w_idx + 6'd1;
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - self-checking bench for sha256_msg_schedule
module tb_sha256_msg_schedule;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic [511:0] blk_data = '0;
    logic         w_valid;
    logic         w_ready = 1'b0;
    logic [31:0]  w_data;
    logic [5:0]   w_idx;
    logic         w_last;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_w [64];
    logic [31:0] got_w [64];

    logic        tv [160];
    logic [5:0]  ti [160];
    logic [31:0] td [160];

    typedef struct {
        string       name;
        logic [5:0]  idx;
        logic [31:0] exp;
    } vec_t;

    vec_t abc_tab [4];
    vec_t hel_tab [3];

`ifdef SHA256_SCHED_B2B_EN
    localparam int EXP_GAP = 0;
`else
    localparam int EXP_GAP = 1;
`endif

    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] HEL_BLK = {32'h68656c6c, 32'h6f20776f, 32'h726c6480, 384'h0, 32'h00000058};

    always #5 clk = ~clk;

    sha256_msg_schedule #(.WORD_W(32), .ROUNDS(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_idx     (w_idx),
        .w_last    (w_last),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ms0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ms1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic model(input logic [511:0] b);
        for (int t = 0; t < 16; t++) exp_w[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            exp_w[t] = ms1(exp_w[t-2]) + exp_w[t-7] + ms0(exp_w[t-15]) + exp_w[t-16];
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
        return b;
    endfunction

    // Send one block, collect 64 words, check protocol, stalls and word values.
    task automatic run_block(input logic [511:0] b, input bit bp, input bit scramble, input string tag);
        int cyc;
        int n;
        int viol;
        int lastcnt;
        int done_cyc;
        bit stalled;
        logic [31:0] hd;
        logic [5:0]  hi;
        logic        hl;
        model(b);
        @(negedge clk);
        blk_data  = b;
        blk_valid = 1'b1;
        w_ready   = 1'b0;
        cyc = 0;
        while (!blk_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_accept"}, blk_ready, 1);
        @(negedge clk);
        blk_valid = 1'b0;
        check({tag, "_lat1"}, w_valid, 1);
        n = 0; cyc = 1; viol = 0; lastcnt = 0; done_cyc = 0; stalled = 0;
        hd = '0; hi = '0; hl = 1'b0;
        while (n < 64 && cyc < 2000) begin
            if (scramble) blk_data = rand_blk();
            if (stalled && (w_data !== hd || w_idx !== hi || w_last !== hl || w_valid !== 1'b1)) viol++;
            if (w_last !== (w_valid && w_idx == 6'd63)) viol++;
            if (w_valid) begin
                if (w_idx !== 6'(n)) viol++;
                w_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (w_ready) begin
                    got_w[n] = w_data;
                    if (w_last) lastcnt++;
                    n++;
                    stalled = 0;
                    if (n == 64) done_cyc = cyc;
                end else begin
                    stalled = 1;
                    hd = w_data; hi = w_idx; hl = w_last;
                end
            end else begin
                viol++;
                w_ready = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        w_ready = 1'b0;
        check({tag, "_count"}, n, 64);
        check({tag, "_protocol"}, viol, 0);
        check({tag, "_lastcnt"}, lastcnt, 1);
        check({tag, "_gap_valid"}, w_valid, 0);
        check({tag, "_gap_busy"}, busy, 0);
        if (!bp) check({tag, "_cycles"}, done_cyc, 64);
        for (int t = 0; t < 64; t++)
            check($sformatf("%s_w%0d", tag, t), got_w[t], exp_w[t]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] blk_a;
        logic [511:0] blk_b;
        int cyc;
        int k63;
        int k0;
        bit acc_b;

        abc_tab[0] = '{"abc_W0",  6'd0,  32'h61626380};
        abc_tab[1] = '{"abc_W15", 6'd15, 32'h00000018};
        abc_tab[2] = '{"abc_W16", 6'd16, 32'h61626380};
        abc_tab[3] = '{"abc_W17", 6'd17, 32'h000f0000};
        hel_tab[0] = '{"hel_W0",  6'd0,  32'h68656c6c};
        hel_tab[1] = '{"hel_W2",  6'd2,  32'h726c6480};
        hel_tab[2] = '{"hel_W15", 6'd15, 32'h00000058};

        #1;
        check("rst_w_valid", w_valid, 0);
        check("rst_w_idx", w_idx, 0);
        check("rst_w_last", w_last, 0);
        check("rst_busy", busy, 0);
        check("rst_w_data", w_data, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_blk_ready", blk_ready, 1);

        run_block(ABC_BLK, 1'b0, 1'b0, "abc");
        for (int i = 0; i < 4; i++)
            check(abc_tab[i].name, got_w[abc_tab[i].idx], abc_tab[i].exp);

        run_block(ABC_BLK, 1'b1, 1'b0, "abc_bp");
        run_block(ABC_BLK, 1'b0, 1'b1, "abc_scr");
        for (int r = 0; r < 20; r++)
            run_block(rand_blk(), 1'b1, 1'b0, $sformatf("rnd%0d", r));

        // Two blocks back-to-back with blk_valid held high.
        blk_a = rand_blk();
        blk_b = rand_blk();
        @(negedge clk);
        blk_data = blk_a; blk_valid = 1'b1; w_ready = 1'b1;
        @(negedge clk);
        blk_data = blk_b;
        acc_b = 0;
        for (int k = 0; k < 160; k++) begin
            tv[k] = w_valid; ti[k] = w_idx; td[k] = w_data;
            if (acc_b) blk_valid = 1'b0;
            else if (blk_valid && blk_ready) acc_b = 1;
            @(negedge clk);
        end
        w_ready = 1'b0;
        check("b2b_accept_b", acc_b, 1);
        check("b2b_a_w0", td[0], blk_a[511:480]);
        k63 = -1; k0 = -1;
        for (int k = 0; k < 160; k++) if (k63 < 0 && tv[k] && ti[k] == 6'd63) k63 = k;
        for (int k = 0; k < 160; k++) if (k0 < 0 && k > k63 && k63 >= 0 && tv[k] && ti[k] == 6'd0) k0 = k;
        check("b2b_gap", k0 - k63 - 1, EXP_GAP);
        model(blk_b);
        if (k0 >= 0 && k0 + 63 < 160) begin
            check("b2b_b_w0", td[k0], blk_b[511:480]);
            for (int j = 0; j < 64; j++) begin
                check($sformatf("b2b_b_w%0d", j), td[k0 + j], exp_w[j]);
                check($sformatf("b2b_b_idx%0d", j), ti[k0 + j], j);
            end
        end else begin
            check("b2b_b_window", k0, 65);
        end
        repeat (3) @(negedge clk);
        check("b2b_idle", busy, 0);

        // Reset pulsed mid-block at w_idx 30.
        @(negedge clk);
        blk_data = ABC_BLK; blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0; w_ready = 1'b1;
        cyc = 0;
        while (!(w_valid && w_idx == 6'd30) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_reach30", w_idx, 30);
        w_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_w_valid", w_valid, 0);
        check("mid_rst_w_idx", w_idx, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_w_last", w_last, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_blk_ready", blk_ready, 1);
        w_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("mid_rst_quiet%0d", k), w_valid, 0);
        end
        w_ready = 1'b0;
        run_block(HEL_BLK, 1'b1, 1'b0, "hel");
        for (int i = 0; i < 3; i++)
            check(hel_tab[i].name, got_w[hel_tab[i].idx], hel_tab[i].exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
